// File: rtl/hrm_leds_pkg.sv
// Shared definitions for the LED pattern controller: register map offsets,
// CTRL field layout, pattern modes and FSM state encoding.
package hrm_leds_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned RATE_W = 3;
    localparam int unsigned POS_W  = 3;

    localparam logic [MODE_W-1:0] MODE_DIRECT = 2'b00;
    localparam logic [MODE_W-1:0] MODE_BLINK  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ROTATE = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'b11;

    localparam int unsigned CTRL_MODE_LSB = 0;
    localparam int unsigned CTRL_RATE_LSB = 2;
    localparam int unsigned CTRL_RUN_BIT  = 5;

    localparam logic [7:0] OFS_DATA = 8'd0;
    localparam logic [7:0] OFS_CTRL = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    // Implemented CTRL bits [5:0]; [7:6] are not stored.
    typedef struct packed {
        logic              run;
        logic [RATE_W-1:0] rate;
        logic [MODE_W-1:0] mode;
    } ctrl_t;

    function automatic logic ctrl_active(input ctrl_t c);
        return c.run && (c.mode != MODE_DIRECT);
    endfunction

endpackage

// File: rtl/leds_prescaler.sv
// Free-running clk divider: tick_c pulses once every CLK_DIV cycles while enabled.
module leds_prescaler #(
    parameter int unsigned CLK_DIV = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick_c
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero while disabled so each run starts from a full period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/leds_pattern_ctrl.sv
// Memory-mapped LED controller: arbitrates the LEDS register write port between
// CPU DATA writes and a prescaled blink/rotate/bounce pattern engine.
module leds_pattern_ctrl
    import hrm_leds_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h0A,
    parameter int unsigned CLK_DIV    = 12000,
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            addr,
    input  logic                  write_en,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout,
    output logic                  led_we,
    output logic [data_width-1:0] led_din,
    output logic                  busy
);
    localparam int unsigned DW = data_width;
    localparam logic [7:0] ADDR_DATA = 8'(BASE_ADDR + OFS_DATA);
    localparam logic [7:0] ADDR_CTRL = 8'(BASE_ADDR + OFS_CTRL);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d, ctrl_new_c;
    logic [DW-1:0]     shadow_q, shadow_d;
    logic [DW-1:0]     led_din_q, led_din_d;
    logic              led_we_q, led_we_d;
    logic [RATE_W-1:0] ratecnt_q, ratecnt_d;
    logic              phase_q, phase_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              data_wr_c, ctrl_wr_c, tick_c;

    assign data_wr_c = write_en && (addr == ADDR_DATA);
    assign ctrl_wr_c = write_en && (addr == ADDR_CTRL);

    always_comb begin
        ctrl_new_c      = '0;
        ctrl_new_c.mode = din[CTRL_MODE_LSB +: MODE_W];
        ctrl_new_c.rate = din[CTRL_RATE_LSB +: RATE_W];
        ctrl_new_c.run  = din[CTRL_RUN_BIT];
    end

    leds_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q != ST_IDLE),
        .clear  (ctrl_wr_c),
        .tick_c (tick_c)
    );

    // Next-state, port arbitration and pattern step. Priority: CTRL write,
    // then DATA write, then the scheduled step.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        shadow_d  = shadow_q;
        led_din_d = led_din_q;
        led_we_d  = 1'b0;
        ratecnt_d = ratecnt_q;
        phase_d   = phase_q;
        pos_d     = pos_q;
        dir_d     = dir_q;

        if (tick_c) begin
            ratecnt_d = (ratecnt_q == ctrl_q.rate) ? '0 : ratecnt_q + RATE_W'(1);
        end

        unique case (state_q)
            ST_IDLE: if (ctrl_active(ctrl_q)) state_d = ST_WAIT;
            ST_WAIT: if (tick_c && (ratecnt_q == ctrl_q.rate)) state_d = ST_STEP;
            ST_STEP: state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_wr_c) begin
            ctrl_d    = ctrl_new_c;
            ratecnt_d = '0;
            phase_d   = 1'b0;
            pos_d     = '0;
            dir_d     = 1'b0;
            if (!ctrl_active(ctrl_new_c)) begin
                state_d   = ST_IDLE;
                led_din_d = shadow_q;
                led_we_d  = 1'b1;
            end else if (state_q != ST_IDLE) begin
                state_d = ST_WAIT;
            end
        end else if (data_wr_c) begin
            shadow_d  = din;
            led_din_d = din;
            led_we_d  = 1'b1;
        end else if (state_q == ST_STEP) begin
            led_we_d = 1'b1;
            case (ctrl_q.mode)
                MODE_BLINK: begin
                    phase_d   = !phase_q;
                    led_din_d = phase_d ? '0 : shadow_q;
                end
                MODE_ROTATE: begin
                    led_din_d = {led_din_q[DW-2:0], led_din_q[DW-1]};
                end
                MODE_BOUNCE: begin
                    led_din_d = DW'(1) << pos_q;
                    // Reverse at each end so both endpoints are shown once per pass.
                    if (!dir_q) begin
                        if (pos_q == POS_W'(7)) begin
                            dir_d = 1'b1;
                            pos_d = POS_W'(6);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == POS_W'(0)) begin
                            dir_d = 1'b0;
                            pos_d = POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                default: led_we_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            shadow_q  <= '0;
            led_din_q <= '0;
            led_we_q  <= 1'b0;
            ratecnt_q <= '0;
            phase_q   <= 1'b0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            shadow_q  <= shadow_d;
            led_din_q <= led_din_d;
            led_we_q  <= led_we_d;
            ratecnt_q <= ratecnt_d;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        dout = '0;
        if (addr == ADDR_DATA) begin
            dout = led_din_q;
        end else if (addr == ADDR_CTRL) begin
            dout = DW'(ctrl_q);
        end
    end

    assign led_we  = led_we_q;
    assign led_din = led_din_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
